// File: rtl/fwd_scoreboard.sv
// Forwarding and hazard unit beside ID: tracks in-flight register writes across
// DEPTH downstream stages, picks operand sources and stalls on not-yet-ready results.
module fwd_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_RDY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [NSRC*REG_AW-1:0]   id_src_addr,
    input  logic [NSRC*DATA_W-1:0]   id_src_data,
    input  logic                     id_wen,
    input  logic [REG_AW-1:0]        id_dst_addr,
    input  logic                     id_is_load,
    input  logic [DEPTH*DATA_W-1:0]  stg_data,
    input  logic                     pipe_hold,
    input  logic                     flush,
    output logic [NSRC*DATA_W-1:0]   fwd_data,
    output logic [NSRC*3-1:0]        fwd_sel,
    output logic                     stall,
    output logic [15:0]              stall_cnt
);

    logic [DEPTH-1:0]  ent_v;
    logic [DEPTH-1:0]  ent_wen;
    logic [REG_AW-1:0] ent_dst [DEPTH];
    logic [2:0]        ent_rdy [DEPTH];

    logic [NSRC-1:0]   hit;
    logic [NSRC-1:0]   hit_rdy;
    logic [NSRC-1:0]   not_ready;
    logic [2:0]        hit_sel  [NSRC];
    logic [DATA_W-1:0] hit_data [NSRC];
    logic              enter;

    // Scan oldest to youngest so the youngest matching entry overwrites any older one.
    always_comb begin
        hit     = '0;
        hit_rdy = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit_sel[i]  = '0;
            hit_data[i] = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (ent_v[k] && ent_wen[k] &&
                    ent_dst[k] == id_src_addr[i*REG_AW +: REG_AW] &&
                    id_src_addr[i*REG_AW +: REG_AW] != '0) begin
                    hit[i]      = 1'b1;
                    hit_rdy[i]  = (3'(k) >= ent_rdy[k]);
                    hit_sel[i]  = 3'(k + 1);
                    hit_data[i] = stg_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        fwd_data = id_src_data;
        fwd_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (hit[i] && hit_rdy[i]) begin
                fwd_data[i*DATA_W +: DATA_W] = hit_data[i];
                fwd_sel[i*3 +: 3]            = hit_sel[i];
            end
        end
        not_ready = hit & ~hit_rdy;
        stall     = id_valid & ~flush & (|not_ready);
        enter     = id_valid & ~stall & ~flush;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_v     <= '0;
            stall_cnt <= '0;
        end else if (!pipe_hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_v[k] <= ent_v[k-1];
            end
            ent_v[0] <= enter;
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    // Payload fields are qualified by ent_v, so they need no reset.
    always_ff @(posedge clk) begin
        if (!pipe_hold) begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_wen[k] <= ent_wen[k-1];
                ent_dst[k] <= ent_dst[k-1];
                ent_rdy[k] <= ent_rdy[k-1];
            end
            ent_wen[0] <= id_wen;
            ent_dst[0] <= id_dst_addr;
            ent_rdy[0] <= id_is_load ? 3'(LOAD_RDY) : 3'd0;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard cases and random traffic on the default
// configuration against an in-flight queue model, plus two alternate parameter sets.
module tb_fwd_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int c3cyc = 0;

    // default instance
    logic        rst_n, id_valid, id_wen, id_is_load, pipe_hold, flush;
    logic [9:0]  id_src_addr;
    logic [63:0] id_src_data;
    logic [4:0]  id_dst_addr;
    logic [95:0] stg_data;
    logic [63:0] fwd_data;
    logic [5:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    // DEPTH=5, NSRC=3, LOAD_RDY=3 instance
    logic         b_valid, b_wen, b_is_load, b_hold, b_flush;
    logic [14:0]  b_src_addr;
    logic [95:0]  b_src_data;
    logic [4:0]   b_dst;
    logic [159:0] b_stg;
    logic [95:0]  b_fwd_data;
    logic [8:0]   b_fwd_sel;
    logic         b_stall;
    logic [15:0]  b_cnt;

    // DEPTH=7, NSRC=1, LOAD_RDY=6 instance, driven with a constant self-dependent load
    logic         rst3_n, c_valid, c_wen, c_is_load, c_hold, c_flush;
    logic [4:0]   c_src_addr, c_dst;
    logic [31:0]  c_src_data;
    logic [223:0] c_stg;
    logic [31:0]  c_fwd_data;
    logic [2:0]   c_fwd_sel;
    logic         c_stall;
    logic [15:0]  c_cnt;

    fwd_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_data(id_src_data), .id_wen(id_wen), .id_dst_addr(id_dst_addr),
        .id_is_load(id_is_load), .stg_data(stg_data), .pipe_hold(pipe_hold), .flush(flush),
        .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_scoreboard #(.DATA_W(32), .REG_AW(5), .DEPTH(5), .NSRC(3), .LOAD_RDY(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(b_valid), .id_src_addr(b_src_addr),
        .id_src_data(b_src_data), .id_wen(b_wen), .id_dst_addr(b_dst),
        .id_is_load(b_is_load), .stg_data(b_stg), .pipe_hold(b_hold), .flush(b_flush),
        .fwd_data(b_fwd_data), .fwd_sel(b_fwd_sel), .stall(b_stall), .stall_cnt(b_cnt)
    );

    fwd_scoreboard #(.DATA_W(32), .REG_AW(5), .DEPTH(7), .NSRC(1), .LOAD_RDY(6)) dut_c (
        .clk(clk), .rst_n(rst3_n), .id_valid(c_valid), .id_src_addr(c_src_addr),
        .id_src_data(c_src_data), .id_wen(c_wen), .id_dst_addr(c_dst),
        .id_is_load(c_is_load), .stg_data(c_stg), .pipe_hold(c_hold), .flush(c_flush),
        .fwd_data(c_fwd_data), .fwd_sel(c_fwd_sel), .stall(c_stall), .stall_cnt(c_cnt)
    );

    // Reference model: queue of in-flight instructions, index 0 = youngest (EX).
    typedef struct packed {
        logic       v;
        logic       wen;
        logic [4:0] dst;
        logic       ld;
    } ent_t;

    ent_t pipe[$];
    int   exp_cnt;
    logic exp_stall;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic wen, input logic [4:0] dst,
                                 input logic ld, input logic [4:0] s0, input logic [4:0] s1,
                                 input logic hold, input logic flsh);
        id_valid    = v;
        id_wen      = wen;
        id_dst_addr = dst;
        id_is_load  = ld;
        id_src_addr = {s1, s0};
        pipe_hold   = hold;
        flush       = flsh;
        id_src_data = {$urandom, $urandom};
        stg_data    = {$urandom, $urandom, $urandom};
        #1;
    endtask

    task automatic checkModel();
        logic [4:0] src;
        int         found;
        int         need;
        bit         any_nr;
        any_nr = 0;
        for (int i = 0; i < 2; i++) begin
            src   = id_src_addr[i*5 +: 5];
            found = -1;
            for (int k = 0; k < pipe.size(); k++) begin
                if (pipe[k].v && pipe[k].wen && pipe[k].dst == src && src != 5'd0) begin
                    found = k;
                    break;
                end
            end
            need = (found >= 0 && pipe[found].ld) ? 1 : 0;
            if (found >= 0 && found < need) begin
                any_nr = 1;
                checkOutput($sformatf("m_sel%0d_wait", i), 64'(fwd_sel[i*3 +: 3]), 64'd0);
            end else if (found >= 0) begin
                checkOutput($sformatf("m_sel%0d_fwd", i), 64'(fwd_sel[i*3 +: 3]), 64'(found + 1));
                checkOutput($sformatf("m_data%0d_fwd", i), 64'(fwd_data[i*32 +: 32]),
                            64'(stg_data[found*32 +: 32]));
            end else begin
                checkOutput($sformatf("m_sel%0d_rf", i), 64'(fwd_sel[i*3 +: 3]), 64'd0);
                checkOutput($sformatf("m_data%0d_rf", i), 64'(fwd_data[i*32 +: 32]),
                            64'(id_src_data[i*32 +: 32]));
            end
        end
        exp_stall = id_valid && !flush && any_nr;
        checkOutput("m_stall", 64'(stall), 64'(exp_stall));
        checkOutput("m_stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
    endtask

    task automatic tick();
        ent_t e;
        checkModel();
        @(posedge clk);
        if (!rst_n) begin
            foreach (pipe[k]) pipe[k].v = 1'b0;
            exp_cnt = 0;
        end else if (!pipe_hold) begin
            e.v   = id_valid && !flush && !exp_stall;
            e.wen = id_wen;
            e.dst = id_dst_addr;
            e.ld  = id_is_load;
            pipe.push_front(e);
            void'(pipe.pop_back());
            if (exp_stall && exp_cnt < 65535) exp_cnt++;
        end
        if (rst3_n) c3cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        b_valid = 0; b_wen = 0; b_is_load = 0; b_hold = 0; b_flush = 0;
        b_src_addr = '0; b_dst = '0; b_src_data = '0; b_stg = '0;
        c_valid = 1; c_wen = 1; c_is_load = 1; c_hold = 0; c_flush = 0;
        c_src_addr = 5'd1; c_dst = 5'd1;
        c_src_data = $urandom;
        c_stg = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 3; k++) pipe.push_back('0);
        exp_cnt   = 0;
        exp_stall = 0;
        @(negedge clk);

        applyStimulus(1, 1, 3, 1, 3, 4, 0, 0);
        tick();
        tick();
        rst3_n = 1'b1;

        // DEPTH=7/LOAD_RDY=6: one entry every 7 cycles, six stall cycles in between
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (700) tick();
        checkOutput("c_cnt_700", 64'(c_cnt), 64'd600);

        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 5, 6, 0, 0);
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_sel", 64'(fwd_sel), 64'd0);
        checkOutput("rst_data", fwd_data, id_src_data);
        tick();

        // ALU back-to-back
        applyStimulus(1, 1, 3, 0, 1, 2, 0, 0);
        tick();
        applyStimulus(1, 1, 4, 0, 3, 3, 0, 0);
        stg_data[31:0] = 32'h11;
        #1;
        checkOutput("alu_sel", 64'(fwd_sel), 64'(6'o11));
        checkOutput("alu_data", fwd_data, 64'h00000011_00000011);
        checkOutput("alu_stall", 64'(stall), 64'd0);
        tick();

        // Load-use
        applyStimulus(1, 1, 5, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 6, 0, 5, 1, 0, 0);
        checkOutput("lu_stall1", 64'(stall), 64'd1);
        checkOutput("lu_sel1_a", 64'(fwd_sel[5:3]), 64'd0);
        tick();
        applyStimulus(1, 1, 6, 0, 5, 1, 0, 0);
        stg_data[63:32] = 32'hABCD;
        #1;
        checkOutput("lu_stall2", 64'(stall), 64'd0);
        checkOutput("lu_sel0", 64'(fwd_sel[2:0]), 64'd2);
        checkOutput("lu_data0", 64'(fwd_data[31:0]), 64'hABCD);
        checkOutput("lu_sel1_b", 64'(fwd_sel[5:3]), 64'd0);
        tick();
        checkOutput("lu_cnt", 64'(stall_cnt), 64'd1);

        // Priority: youngest r7 wins over older r7
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 8, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 9, 0, 7, 0, 0, 0);
        stg_data[31:0]  = 32'h44;
        stg_data[95:64] = 32'h22;
        #1;
        checkOutput("pri_sel", 64'(fwd_sel[2:0]), 64'd1);
        checkOutput("pri_data", 64'(fwd_data[31:0]), 64'h44);
        tick();

        // Register 0: a load to r0 neither forwards nor stalls
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r0_sel", 64'(fwd_sel), 64'd0);
        checkOutput("r0_data", fwd_data, id_src_data);
        checkOutput("r0_stall", 64'(stall), 64'd0);
        tick();

        // Hold during load-use stall
        applyStimulus(1, 1, 10, 1, 0, 0, 0, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 1, 11, 0, 10, 0, 1, 0);
            checkOutput($sformatf("hold_stall%0d", c), 64'(stall), 64'd1);
            checkOutput($sformatf("hold_cnt%0d", c), 64'(stall_cnt), 64'd1);
            tick();
        end
        applyStimulus(1, 1, 11, 0, 10, 0, 0, 0);
        checkOutput("hold_rel_stall", 64'(stall), 64'd1);
        tick();
        checkOutput("hold_rel_cnt", 64'(stall_cnt), 64'd2);
        applyStimulus(1, 1, 11, 0, 10, 0, 0, 0);
        checkOutput("hold_fwd_sel", 64'(fwd_sel[2:0]), 64'd2);
        checkOutput("hold_fwd_stall", 64'(stall), 64'd0);
        tick();

        // Flush on a stalled consumer enters a bubble
        applyStimulus(1, 1, 12, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 13, 0, 12, 0, 0, 1);
        checkOutput("fl_stall", 64'(stall), 64'd0);
        tick();
        applyStimulus(1, 1, 14, 0, 12, 13, 0, 0);
        checkOutput("fl_sel0", 64'(fwd_sel[2:0]), 64'd2);
        checkOutput("fl_bubble", 64'(fwd_sel[5:3]), 64'd0);
        checkOutput("fl_stall2", 64'(stall), 64'd0);
        tick();

        // Reset in the middle of a stall
        applyStimulus(1, 1, 15, 1, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 16, 0, 15, 0, 0, 0);
        checkOutput("rms_stall", 64'(stall), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1, 1, 16, 0, 15, 15, 0, 0);
        checkOutput("rms_stall2", 64'(stall), 64'd0);
        checkOutput("rms_cnt", 64'(stall_cnt), 64'd0);
        checkOutput("rms_sel", 64'(fwd_sel), 64'd0);
        tick();

        // Random traffic on a small register range so hazards are frequent
        repeat (2000) begin
            rst_n = ($urandom_range(0, 49) != 0);
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                          5'($urandom_range(0, 5)), $urandom_range(0, 2) == 0,
                          5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            tick();
        end
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // DEPTH=5/NSRC=3/LOAD_RDY=3 load-use
        b_valid = 1; b_wen = 1; b_is_load = 1; b_dst = 5'd5; b_src_addr = '0;
        b_src_data = {$urandom, $urandom, $urandom};
        b_stg = {$urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        checkOutput("b_ld_stall", 64'(b_stall), 64'd0);
        tick();
        b_is_load = 0; b_dst = 5'd6; b_src_addr = {5'd5, 5'd2, 5'd5};
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("b_stall%0d", c), 64'(b_stall), 64'd1);
            tick();
        end
        b_stg[127:96] = 32'hBEEF;
        #1;
        checkOutput("b_stall_end", 64'(b_stall), 64'd0);
        checkOutput("b_sel", 64'(b_fwd_sel), 64'(9'o404));
        checkOutput("b_data0", 64'(b_fwd_data[31:0]), 64'hBEEF);
        checkOutput("b_data1", 64'(b_fwd_data[63:32]), 64'(b_src_data[63:32]));
        checkOutput("b_data2", 64'(b_fwd_data[95:64]), 64'hBEEF);
        tick();
        b_valid = 0;
        #1;
        checkOutput("b_cnt", 64'(b_cnt), 64'd3);

        // Let the DEPTH=7 instance accumulate more than 65535 stall cycles
        while (c3cyc < 76700) tick();
        checkOutput("c_cnt_sat", 64'(c_cnt), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
